// File: rtl/cnn_stream_feeder.sv
// Multi-channel write sequencer: replays preloaded words into the CNN input buffers,
// each channel following its own write/skip schedule with gap/skip delays and a ready timeout.
module cnn_stream_feeder #(
  parameter int NUM_CH        = 2,
  parameter int DATA_WIDTH    = 18,
  parameter int DEPTH         = 16,
  parameter int SCHED_LEN_MAX = 32,
  parameter int GAP_CYCLES    = 1,
  parameter int SKIP_CYCLES   = 50,
  parameter int TIMEOUT       = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               word_load_en,
  input  logic [$clog2(NUM_CH)-1:0]          word_ch,
  input  logic [$clog2(DEPTH)-1:0]           word_addr,
  input  logic [DATA_WIDTH-1:0]              word_data,
  input  logic                               sched_load_en,
  input  logic [$clog2(NUM_CH)-1:0]          sched_ch,
  input  logic [$clog2(SCHED_LEN_MAX)-1:0]   sched_idx,
  input  logic                               sched_bit,
  input  logic                               cfg_en,
  input  logic [$clog2(NUM_CH)-1:0]          cfg_ch,
  input  logic [$clog2(SCHED_LEN_MAX):0]     cfg_len,
  input  logic [$clog2(DEPTH):0]             cfg_words,
  input  logic [NUM_CH-1:0]                  ch_ready,
  output logic [NUM_CH-1:0]                  ch_we,
  output logic [NUM_CH*DATA_WIDTH-1:0]       ch_data,
  output logic                               busy,
  output logic                               done,
  output logic [NUM_CH-1:0]                  err
);

  localparam int AW      = $clog2(DEPTH);
  localparam int SW      = $clog2(SCHED_LEN_MAX);
  localparam int LW      = SW + 1;
  localparam int WW      = AW + 1;
  localparam int DLY_MAX = (GAP_CYCLES > SKIP_CYCLES) ? GAP_CYCLES : SKIP_CYCLES;
  localparam int DLYW    = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
  localparam int TOW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Delay counters run N-1 down to 0 so a GAP/SKIP state lasts exactly N cycles.
  localparam logic [DLYW-1:0] GAP_LOAD  = DLYW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [DLYW-1:0] SKIP_LOAD = DLYW'((SKIP_CYCLES > 0) ? SKIP_CYCLES - 1 : 0);
  localparam logic [TOW-1:0]  TO_LAST   = TOW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NEXT  = 3'd1,
    S_WRITE = 3'd2,
    S_GAP   = 3'd3,
    S_SKIP  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Per-channel FSM state, left visible for debug and checker binding.
  state_e              state       [NUM_CH];
  logic [LW-1:0]       entry       [NUM_CH];
  logic [WW-1:0]       word_idx    [NUM_CH];
  logic [DLYW-1:0]     dly         [NUM_CH];
  logic [TOW-1:0]      to_cnt      [NUM_CH];
  logic [LW-1:0]       cfg_len_q   [NUM_CH];
  logic [WW-1:0]       cfg_words_q [NUM_CH];

  logic [DATA_WIDTH-1:0]    word_mem  [NUM_CH][DEPTH];
  logic [SCHED_LEN_MAX-1:0] sched_mem [NUM_CH];

  logic launch;

  always_comb begin
    busy = 1'b0;
    done = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (state[c] != S_IDLE && state[c] != S_DONE) busy = 1'b1;
      if (state[c] != S_DONE) done = 1'b0;
    end
  end

  assign launch = start && !busy;

  // Word and schedule storage survive reset so a replay can follow a reset.
  always_ff @(posedge clk) begin
    if (word_load_en && !busy) word_mem[word_ch][word_addr] <= word_data;
    if (sched_load_en && !busy) sched_mem[sched_ch][sched_idx] <= sched_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cfg_len_q[c]   <= '0;
        cfg_words_q[c] <= '0;
      end
    end else if (cfg_en && !busy) begin
      cfg_len_q[cfg_ch]   <= cfg_len;
      cfg_words_q[cfg_ch] <= cfg_words;
    end
  end

  // Handshake: a word transfers on every rising edge where ch_we[c] && ch_ready[c];
  // ch_we/ch_data stay stable from entry into WRITE until that edge (or the timeout).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state[c]    <= S_IDLE;
        entry[c]    <= '0;
        word_idx[c] <= '0;
        dly[c]      <= '0;
        to_cnt[c]   <= '0;
      end
      ch_we   <= '0;
      ch_data <= '0;
      err     <= '0;
    end else begin
      if (launch) err <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (launch) begin
          state[c]    <= S_NEXT;
          entry[c]    <= '0;
          word_idx[c] <= '0;
          dly[c]      <= '0;
          to_cnt[c]   <= '0;
          ch_we[c]    <= 1'b0;
        end else begin
          case (state[c])
            S_IDLE: ;
            S_NEXT: begin
              if (entry[c] == cfg_len_q[c]) begin
                state[c] <= S_DONE;
              end else if (sched_mem[c][entry[c][SW-1:0]]) begin
                if (word_idx[c] < cfg_words_q[c]) begin
                  ch_data[c*DATA_WIDTH +: DATA_WIDTH] <= word_mem[c][word_idx[c][AW-1:0]];
                  ch_we[c]  <= 1'b1;
                  to_cnt[c] <= '0;
                  state[c]  <= S_WRITE;
                end else begin
                  state[c] <= S_DONE;
                end
              end else if (SKIP_CYCLES == 0) begin
                entry[c] <= entry[c] + LW'(1);
              end else begin
                dly[c]   <= SKIP_LOAD;
                state[c] <= S_SKIP;
              end
            end
            S_WRITE: begin
              if (ch_ready[c]) begin
                ch_we[c]    <= 1'b0;
                word_idx[c] <= word_idx[c] + WW'(1);
                entry[c]    <= entry[c] + LW'(1);
                if (GAP_CYCLES == 0) begin
                  state[c] <= S_NEXT;
                end else begin
                  dly[c]   <= GAP_LOAD;
                  state[c] <= S_GAP;
                end
              end else if (to_cnt[c] == TO_LAST) begin
                ch_we[c] <= 1'b0;
                err[c]   <= 1'b1;
                state[c] <= S_DONE;
              end else begin
                to_cnt[c] <= to_cnt[c] + TOW'(1);
              end
            end
            S_GAP: begin
              if (dly[c] == '0) state[c] <= S_NEXT;
              else dly[c] <= dly[c] - DLYW'(1);
            end
            S_SKIP: begin
              if (dly[c] == '0) begin
                entry[c] <= entry[c] + LW'(1);
                state[c] <= S_NEXT;
              end else begin
                dly[c] <= dly[c] - DLYW'(1);
              end
            end
            S_DONE: begin
              // The cycle every channel sits in DONE is the done pulse; all leave together.
              if (done) state[c] <= S_IDLE;
            end
            default: state[c] <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_cnn_stream_feeder.sv
// Randomized scoreboard bench for cnn_stream_feeder: a schedule-level reference model
// predicts every accepted word (and its cycle when ready is held high).
module tb_cnn_stream_feeder;
  localparam int DW    = 18;
  localparam int DEPTH = 16;
  localparam int SLM   = 32;
  localparam int GAP   = 1;
  localparam int SKIP  = 50;
  localparam int TO    = 16;

  logic          clk = 1'b0;
  logic          reset, start;
  logic          word_load_en, sched_load_en, cfg_en;
  logic [0:0]    word_ch, sched_ch, cfg_ch;
  logic [3:0]    word_addr;
  logic [DW-1:0] word_data;
  logic [4:0]    sched_idx;
  logic          sched_bit;
  logic [5:0]    cfg_len;
  logic [4:0]    cfg_words;
  logic [1:0]    ch_ready, ch_we, err;
  logic [2*DW-1:0] ch_data;
  logic          busy, done;

  cnn_stream_feeder #(
    .NUM_CH(2), .DATA_WIDTH(DW), .DEPTH(DEPTH), .SCHED_LEN_MAX(SLM),
    .GAP_CYCLES(GAP), .SKIP_CYCLES(SKIP), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .word_load_en(word_load_en), .word_ch(word_ch), .word_addr(word_addr), .word_data(word_data),
    .sched_load_en(sched_load_en), .sched_ch(sched_ch), .sched_idx(sched_idx), .sched_bit(sched_bit),
    .cfg_en(cfg_en), .cfg_ch(cfg_ch), .cfg_len(cfg_len), .cfg_words(cfg_words),
    .ch_ready(ch_ready), .ch_we(ch_we), .ch_data(ch_data),
    .busy(busy), .done(done), .err(err)
  );

  // Clock/reset and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Reference model state and scoreboard queues
  logic [DW-1:0] mdl_mem [2][DEPTH];
  logic [31:0]   mdl_sched [2];
  int            mdl_len [2];
  int            mdl_words [2];
  logic [DW-1:0] exp_q0[$], exp_q1[$];
  int            exp_cyc_q0[$], exp_cyc_q1[$];
  int            exp_done_cyc;
  int            done_base;

  int            wr_cnt [2];
  int            stall_cnt [2];
  logic [DW-1:0] held [2];
  bit            stalled [2];
  int            done_cnt = 0;
  int            done_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int c, input logic [DW-1:0] d, input int ec);
    if (c == 0) begin exp_q0.push_back(d); exp_cyc_q0.push_back(ec); end
    else begin exp_q1.push_back(d); exp_cyc_q1.push_back(ec); end
  endtask

  task automatic pop_check(input int c, input logic [DW-1:0] d);
    logic [DW-1:0] e;
    int ec;
    if ((c == 0 && exp_q0.size() == 0) || (c == 1 && exp_q1.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL unexpected_write ch%0d: got data %0h expected no write (cycle %0d)", c, d, cyc);
      return;
    end
    if (c == 0) begin e = exp_q0.pop_front(); ec = exp_cyc_q0.pop_front(); end
    else begin e = exp_q1.pop_front(); ec = exp_cyc_q1.pop_front(); end
    check($sformatf("data_ch%0d", c), 64'(d), 64'(e));
    if (ec >= 0) check($sformatf("write_cycle_ch%0d", c), 64'(cyc), 64'(ec));
  endtask

  // Monitor: samples just after the falling edge, once inputs for the cycle are settled
  always @(negedge clk) begin : monitor
    logic [DW-1:0] d;
    #1;
    if (!reset) begin
      for (int c = 0; c < 2; c++) begin
        d = ch_data[c*DW +: DW];
        if (ch_we[c]) begin
          if (stalled[c]) check($sformatf("hold_data_ch%0d", c), 64'(d), 64'(held[c]));
          if (ch_ready[c]) begin
            wr_cnt[c]++;
            stalled[c] = 1'b0;
            pop_check(c, d);
          end else begin
            stall_cnt[c]++;
            held[c] = d;
            stalled[c] = 1'b1;
          end
        end else begin
          stalled[c] = 1'b0;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Schedule-level model: walks entries, issuing words in order until length or words run out.
  // Cycle n is the one in which start is high; a write entry costs 2+GAP, a skip 1+SKIP.
  task automatic build_expect(input int n, input bit timed, input bit [1:0] to_mask);
    int t, w;
    exp_done_cyc = 0;
    for (int c = 0; c < 2; c++) begin
      t = n + 1;
      w = 0;
      for (int e = 0; e < mdl_len[c]; e++) begin
        if (mdl_sched[c][e]) begin
          if (w >= mdl_words[c] || to_mask[c]) break;
          push_exp(c, mdl_mem[c][w], timed ? t + 1 : -1);
          w++;
          t += 2 + GAP;
        end else begin
          t += 1 + SKIP;
        end
      end
      if (t + 1 > exp_done_cyc) exp_done_cyc = t + 1;
    end
  endtask

  // Driver tasks: each is entered and left just after a falling edge
  task automatic load_cfg_only(input int c, input int len, input int words);
    cfg_en = 1'b1; cfg_ch = 1'(c); cfg_len = 6'(len); cfg_words = 5'(words);
    @(negedge clk);
    cfg_en = 1'b0;
    mdl_len[c] = len;
    mdl_words[c] = words;
  endtask

  task automatic load_cfg(input int c, input int len, input int words, input logic [31:0] sched);
    for (int a = 0; a < DEPTH; a++) begin
      mdl_mem[c][a] = DW'($urandom);
      word_load_en = 1'b1; word_ch = 1'(c); word_addr = 4'(a); word_data = mdl_mem[c][a];
      @(negedge clk);
    end
    word_load_en = 1'b0;
    for (int i = 0; i < SLM; i++) begin
      sched_load_en = 1'b1; sched_ch = 1'(c); sched_idx = 5'(i); sched_bit = sched[i];
      @(negedge clk);
    end
    sched_load_en = 1'b0;
    mdl_sched[c] = sched;
    load_cfg_only(c, len, words);
  endtask

  task automatic start_replay(input bit timed, input bit [1:0] to_mask);
    for (int c = 0; c < 2; c++) begin wr_cnt[c] = 0; stall_cnt[c] = 0; end
    done_base = done_cnt;
    start = 1'b1;
    build_expect(cyc, timed, to_mask);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_replay(input string tag, input bit timed, input bit rand_ready,
                               input logic [1:0] exp_err);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
      if (rand_ready) ch_ready = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
    end
    @(negedge clk);
    @(negedge clk);
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_done_pulses"}, 64'(done_cnt - done_base), 64'd1);
    if (timed) check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done_cyc));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_busy_idle"}, 64'(busy), 64'd0);
    check({tag, "_left_ch0"}, 64'(exp_q0.size()), 64'd0);
    check({tag, "_left_ch1"}, 64'(exp_q1.size()), 64'd0);
    exp_q0.delete(); exp_q1.delete(); exp_cyc_q0.delete(); exp_cyc_q1.delete();
    ch_ready = 2'b11;
  endtask

  initial begin
    logic [31:0] s0, s1;
    bit found;
    int hold;
    reset = 1'b1; start = 1'b0;
    word_load_en = 1'b0; word_ch = '0; word_addr = '0; word_data = '0;
    sched_load_en = 1'b0; sched_ch = '0; sched_idx = '0; sched_bit = 1'b0;
    cfg_en = 1'b0; cfg_ch = '0; cfg_len = '0; cfg_words = '0;
    ch_ready = 2'b11;
    for (int c = 0; c < 2; c++) begin
      mdl_len[c] = 0; mdl_words[c] = 0; mdl_sched[c] = '0;
      wr_cnt[c] = 0; stall_cnt[c] = 0; stalled[c] = 1'b0; held[c] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_we", 64'(ch_we), 64'd0);
    check("reset_data", 64'(ch_data), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_err", 64'(err), 64'd0);

    // Two-channel replay with skips, ready held high
    s0 = 32'h3FFFF & ~32'h404;
    s1 = 32'h3FFFF & ~32'h120;
    load_cfg(0, 18, 16, s0);
    load_cfg(1, 18, 16, s1);
    start_replay(1'b1, 2'b00);
    check("busy_after_start", 64'(busy), 64'd1);
    finish_replay("replay", 1'b1, 1'b0, 2'b00);
    check("replay_writes_ch0", 64'(wr_cnt[0]), 64'd16);
    check("replay_writes_ch1", 64'(wr_cnt[1]), 64'd16);

    // start / loads while busy must be ignored; the follow-up replay proves nothing changed
    start_replay(1'b1, 2'b00);
    repeat (10) @(negedge clk);
    start = 1'b1;
    word_load_en = 1'b1; word_ch = 1'b0; word_addr = 4'd0; word_data = ~mdl_mem[0][0];
    sched_load_en = 1'b1; sched_ch = 1'b0; sched_idx = 5'd0; sched_bit = 1'b0;
    cfg_en = 1'b1; cfg_ch = 1'b0; cfg_len = 6'd0; cfg_words = 5'd0;
    @(negedge clk);
    start = 1'b0; word_load_en = 1'b0; sched_load_en = 1'b0; cfg_en = 1'b0;
    check("busy_during_ignored", 64'(busy), 64'd1);
    finish_replay("ignored", 1'b1, 1'b0, 2'b00);
    start_replay(1'b1, 2'b00);
    finish_replay("replay_again", 1'b1, 1'b0, 2'b00);

    // Backpressure: seven stalled cycles on the first ch0 write
    load_cfg(0, 3, 3, 32'h7);
    load_cfg(1, 2, 16, 32'h3);
    ch_ready = 2'b10;
    start_replay(1'b0, 2'b00);
    hold = 0;
    for (int i = 0; i < 50; i++) begin
      if (ch_we[0]) begin
        if (hold == 7) break;
        hold++;
      end
      @(negedge clk);
    end
    ch_ready = 2'b11;
    finish_replay("backpressure", 1'b0, 1'b0, 2'b00);
    check("backpressure_stalls", 64'(stall_cnt[0]), 64'd7);

    // Timeout on ch0 while ch1 completes
    ch_ready = 2'b10;
    start_replay(1'b0, 2'b01);
    finish_replay("timeout", 1'b0, 1'b0, 2'b01);
    check("timeout_we_cycles", 64'(stall_cnt[0]), 64'(TO));
    start_replay(1'b0, 2'b00);
    check("err_cleared_by_start", 64'(err), 64'd0);
    finish_replay("after_timeout", 1'b0, 1'b0, 2'b00);

    // Word exhaustion, then empty configuration
    load_cfg(0, 5, 3, 32'h1F);
    load_cfg(1, 4, 16, 32'hB);
    start_replay(1'b1, 2'b00);
    finish_replay("exhaust", 1'b1, 1'b0, 2'b00);
    check("exhaust_writes_ch0", 64'(wr_cnt[0]), 64'd3);
    load_cfg_only(0, 0, 16);
    load_cfg_only(1, 0, 16);
    start_replay(1'b1, 2'b00);
    finish_replay("empty", 1'b1, 1'b0, 2'b00);
    check("empty_writes", 64'(wr_cnt[0] + wr_cnt[1]), 64'd0);

    // Reset during a write, then replay from word 0 after reconfiguring lengths
    load_cfg(0, 8, 16, 32'hFF);
    load_cfg(1, 8, 16, 32'hF5);
    start_replay(1'b1, 2'b00);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ch_we[0]) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("reset_mid_found_write", 64'(found), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_we", 64'(ch_we), 64'd0);
    check("reset_mid_busy", 64'(busy), 64'd0);
    check("reset_mid_err", 64'(err), 64'd0);
    check("reset_mid_done", 64'(done), 64'd0);
    reset = 1'b0;
    exp_q0.delete(); exp_q1.delete(); exp_cyc_q0.delete(); exp_cyc_q1.delete();
    mdl_len[0] = 0; mdl_len[1] = 0; mdl_words[0] = 0; mdl_words[1] = 0;
    repeat (3) @(negedge clk);
    check("reset_mid_no_done", 64'(done_cnt - done_base), 64'd0);
    load_cfg_only(0, 8, 16);
    load_cfg_only(1, 8, 16);
    start_replay(1'b1, 2'b00);
    finish_replay("after_reset", 1'b1, 1'b0, 2'b00);

    // Randomized schedules with random backpressure
    for (int r = 0; r < 4; r++) begin
      load_cfg(0, $urandom_range(0, 24), $urandom_range(0, 16), $urandom);
      load_cfg(1, $urandom_range(0, 24), $urandom_range(0, 16), $urandom);
      start_replay(1'b0, 2'b00);
      finish_replay($sformatf("random%0d", r), 1'b0, 1'b1, 2'b00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
